des_sbox_sched: RTL and testbench



---
 rtl/des_sbox_sched.sv | 130 +++++++++++++
 tb/tb_des_sbox_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/des_sbox_sched.sv
// des_sbox_sched: runs a 48-bit DES S-box input through S1..S8 over several cycles, valid/ready on both sides.
// Build option: define DES_SBOX_SCHED_PAR2_EN to evaluate two S-boxes per cycle (4-cycle run instead of 8).
module des_sbox_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [1:48] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [1:32] out_data,
    input  logic        out_ready,
    output logic        busy
);

`ifdef DES_SBOX_SCHED_PAR2_EN
    localparam int IDX_W = 2;
`else
    localparam int IDX_W = 3;
`endif
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    // One entry per S-box: 64 nibbles, row-major (row = {b1,b6}, column = b2..b5), entry 0 in the top nibble.
    localparam logic [255:0] SBOX [0:7] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D70934A6285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [47:0]      r_blk;
    logic [31:0]      r_shadow;
    logic [31:0]      r_out;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_idle;
    logic [31:0]      w_shadow_nxt;

    // Selects chunk `box` of the latched block and looks it up in S(box+1).
    function automatic logic [3:0] f_lookup(input logic [2:0] box, input logic [47:0] blk);
        logic [5:0] chunk;
        logic [5:0] addr;
        chunk = blk[47 - 6*int'(box) -: 6];
        addr  = {chunk[5], chunk[0], chunk[4:1]};
        return SBOX[box][255 - 4*int'(addr) -: 4];
    endfunction

    always_comb begin
        w_shadow_nxt = r_shadow;
`ifdef DES_SBOX_SCHED_PAR2_EN
        w_shadow_nxt[31 - 8*int'(r_idx) -: 4] = f_lookup({r_idx, 1'b0}, r_blk);
        w_shadow_nxt[27 - 8*int'(r_idx) -: 4] = f_lookup({r_idx, 1'b1}, r_blk);
`else
        w_shadow_nxt[31 - 4*int'(r_idx) -: 4] = f_lookup(r_idx, r_blk);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_blk       <= '0;
            r_shadow    <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_idle      <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_blk   <= in_data;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_idle  <= 1'b0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_shadow <= w_shadow_nxt;
                    r_idx    <= r_idx + 1'b1;
                    // Publish only once the last nibble lands so out_data never shows a partial result.
                    if (r_idx == IDX_LAST) begin
                        r_out       <= w_shadow_nxt;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (in_valid) begin
                            r_blk   <= in_data;
                            r_idx   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_RUN;
                        end else begin
                            r_idle  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idle  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // The DONE term has to follow out_ready combinationally to allow a back-to-back accept.
    assign in_ready  = r_idle | (r_out_valid & out_ready);
    assign out_valid = r_out_valid;
    assign out_data  = r_out;
    assign busy      = r_busy;

endmodule

// File: tb/tb_des_sbox_sched.sv
// tb_des_sbox_sched: directed DES S-box vectors, stall/back-to-back, mid-run reset and random back-pressure.
// Honours DES_SBOX_SCHED_PAR2_EN for the expected run length.
module tb_des_sbox_sched;

`ifdef DES_SBOX_SCHED_PAR2_EN
    localparam int RUN_LEN = 4;
`else
    localparam int RUN_LEN = 8;
`endif
    localparam int NRAND = 1000;

    // Reference S-box rows, index box*4 + row, column 0 in the top nibble.
    localparam logic [63:0] SB_ROWS [0:31] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:48] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [1:32] out_data;
    logic        out_ready;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    des_sbox_sched dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] f_ref(input logic [47:0] d);
        logic [31:0] r;
        logic [5:0]  c;
        logic [63:0] row;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            c   = d[47 - 6*k -: 6];
            row = SB_ROWS[k*4 + int'({c[5], c[0]})];
            r[31 - 4*k -: 4] = row[63 - 4*int'(c[4:1]) -: 4];
        end
        return r;
    endfunction

    // Present one block from the next falling edge; returns at the falling edge after the accept edge.
    task automatic send(input logic [47:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        check("send_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at the falling edge just after the accept edge.
    task automatic wait_result(input string tag, input logic [31:0] exp, input logic [31:0] prev);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            if (n == 1) check({tag, "_busy"}, busy, 1);
            if (n == 2) check({tag, "_hold"}, out_data, prev);
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, RUN_LEN);
        check({tag, "_data"}, out_data, exp);
    endtask

    task automatic release_out(input string tag);
        check({tag, "_stall_rdy"}, in_ready, 0);
        out_ready = 1'b1;
        #1;
        check({tag, "_done_rdy"}, in_ready, 1);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check({tag, "_ovalid_clr"}, out_valid, 0);
    endtask

    logic [47:0] vec_d [0:5];
    logic [31:0] vec_e [0:5];
    logic [31:0] last_res;
    logic [31:0] q [$];
    logic [63:0] r64;
    logic        seen;
    int          sent, got, cyc;

    initial begin
        vec_d[0] = 48'h000000000000; vec_e[0] = 32'hEFA72C4D;
        vec_d[1] = 48'hFFFFFFFFFFFF; vec_e[1] = 32'hD9CE3DCB;
        vec_d[2] = 48'h000000001000; vec_e[2] = 32'hEFA72A4D; // S6 in = 000001 -> row1 col0 = 10
        vec_d[3] = 48'h040000000000; vec_e[3] = 32'h0FA72C4D; // S1 in = 000001 -> row1 col0 = 0
        vec_d[4] = 48'h00000000001E; vec_e[4] = 32'hEFA72C47; // S8 in = 011110 -> row0 col15 = 7
        vec_d[5] = 48'h000840000000; vec_e[5] = 32'hEF172C4D; // S3 in = 100001 -> row3 col0 = 1

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b0;

        last_res = '0;
        for (int i = 0; i < 6; i++) begin
            send(vec_d[i]);
            wait_result($sformatf("vec%0d", i), vec_e[i], last_res);
            release_out($sformatf("vec%0d", i));
            last_res = vec_e[i];
        end

        // Stall in DONE while a second block is offered, then handshake and accept on the same edge.
        send(48'h0);
        wait_result("stall1", 32'hEFA72C4D, last_res);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = i[0];
            in_data  = 48'hFFFFFFFFFFFF;
            #1;
            check("stall_in_ready", in_ready, 0);
        end
        check("stall_out_valid", out_valid, 1);
        check("stall_out_data", out_data, 32'hEFA72C4D);
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("b2b_ovalid_clr", out_valid, 0);
        wait_result("b2b", 32'hD9CE3DCB, 32'hEFA72C4D);
        release_out("b2b");

        // Reset in the middle of a run.
        send(48'hFFFFFFFFFFFF);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_busy", busy, 0);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_out_data", out_data, 0);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("mrst_no_valid", seen, 0);
        send(48'h0);
        wait_result("post_rst", 32'hEFA72C4D, 32'h0);
        release_out("post_rst");

        // Random blocks with random back-pressure, scoreboard in order.
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < NRAND && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (!in_valid && sent < NRAND && $urandom_range(0, 9) < 7) begin
                r64      = {$urandom(), $urandom()};
                in_valid = 1'b1;
                in_data  = r64[47:0];
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("rand_extra", 1, 0);
                else check("rand_data", out_data, q.pop_front());
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(f_ref(in_data));
                sent++;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end
        end
        check("rand_got", got, NRAND);
        check("rand_sent", sent, NRAND);
        check("rand_q_empty", q.size(), 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
